// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, registered Instr/PC handed to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky HALT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
        , S_HALT
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic        consume;

    assign PCPlus4   = PC + 32'd4;
    assign imem_addr = PC;
    assign consume   = (state == S_HOLD) && !stall;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_next;
    logic bad_target;

    assign bad_target = PCSrc && (PCTarget[1:0] != 2'b00);
    assign misalign   = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_next  = state;
        pc_next     = PC;
        instr_next  = Instr;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_next = misalign_q;
`endif
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        instr_next = imem_rdata;
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_next = imem_rdata;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                // PCSrc/PCTarget only matter on the consume cycle.
                if (consume) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (bad_target) begin
                        misalign_next = 1'b1;
                        state_next    = S_HALT;
                    end else begin
                        pc_next    = PCSrc ? PCTarget : PCPlus4;
                        state_next = S_REQ;
                    end
`else
                    pc_next    = PCSrc ? (PCTarget & 32'hFFFF_FFFC) : PCPlus4;
                    state_next = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state <= S_IDLE;
            PC    <= RESET_PC;
            Instr <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            PC    <= pc_next;
            Instr <= instr_next;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= misalign_next;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable ready/rvalid latency,
// per-scenario tasks with inline checks against hand-derived addresses and instruction words.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misalign;

    int vectors = 0;
    int miscompares = 0;

    // memory model configuration and state
    int          ready_dly = 0;
    int          rvalid_dly = 0;
    bit          spurious = 1'b0;
    int          wcnt = 0;
    int          rcnt = 0;
    bit          pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] accepted[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .misalign    (misalign)
    );

    function automatic logic [31:0] image(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: evaluated on the falling edge, so its outputs are stable at the next rising edge.
    always @(negedge clk) begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (reset) begin
            wcnt = 0;
            rcnt = 0;
            pend = 1'b0;
        end else if (pend) begin
            if (rcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = image(paddr);
                pend        = 1'b0;
            end else begin
                rcnt = rcnt - 1;
            end
        end else if (imem_req && wcnt >= ready_dly) begin
            imem_ready = 1'b1;
            wcnt       = 0;
            accepted.push_back(imem_addr);
            if (rvalid_dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = image(imem_addr);
            end else begin
                pend  = 1'b1;
                rcnt  = rvalid_dly - 1;
                paddr = imem_addr;
            end
        end else begin
            if (imem_req) wcnt = wcnt + 1;
            imem_rvalid = spurious;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
        ready_dly  = 0;
        rvalid_dly = 0;
        spurious   = 1'b0;
        repeat (2) @(negedge clk);
        accepted.delete();
        reset = 1'b0;
    endtask

    // Run until instr_valid (bounded); report cycles spent and whether imem_addr ever differed from exp_addr.
    task automatic fetch_one(input logic [31:0] exp_addr, output int cycles, output bit addr_bad, output bit got);
        cycles   = 0;
        addr_bad = 1'b0;
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            cycles++;
            if (imem_req && imem_addr !== exp_addr) addr_bad = 1'b1;
            if (instr_valid) got = 1'b1;
        end
    endtask

    // Present consume-cycle redirect inputs, pass one edge, then drive junk redirects that must be ignored.
    task automatic consume(input logic src, input logic [31:0] tgt, output logic v_after);
        PCSrc    = src;
        PCTarget = tgt;
        @(negedge clk);
        #1;
        v_after  = instr_valid;
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0080;
    endtask

    task automatic test_reset();
        int cyc;
        bit bad;
        bit got;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({imem_req, instr_valid, misalign} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctl: req/valid/misalign=%b want 000", {imem_req, instr_valid, misalign});
        end
        vectors++;
        if ({PC, Instr, PCPlus4} !== {RESET_PC, NOP, RESET_PC + 32'd4}) begin
            miscompares++;
            $display("FAIL reset_regs: PC=%h Instr=%h PCPlus4=%h want %h %h %h",
                     PC, Instr, PCPlus4, RESET_PC, NOP, RESET_PC + 32'd4);
        end
        accepted.delete();
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_release: imem_req=%b want 0", imem_req);
        end
        fetch_one(RESET_PC, cyc, bad, got);
        vectors++;
        if (!got || bad || cyc != 2) begin
            miscompares++;
            $display("FAIL first_fetch: got=%0b addr_bad=%0b cycles=%0d want 1 0 2", got, bad, cyc);
        end
    endtask

    task automatic test_sequential();
        int          cyc;
        bit          bad;
        bit          got;
        logic        v;
        logic [31:0] exp;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp = RESET_PC + 32'(4 * k);
            fetch_one(exp, cyc, bad, got);
            vectors++;
            if (!got || bad || {PC, Instr, PCPlus4} !== {exp, image(exp), exp + 32'd4}) begin
                miscompares++;
                $display("FAIL seq_fetch[%0d]: got=%0b bad=%0b PC=%h Instr=%h PCPlus4=%h want PC=%h Instr=%h",
                         k, got, bad, PC, Instr, PCPlus4, exp, image(exp));
            end
            if (k > 0) begin
                vectors++;
                if (cyc != 1) begin
                    miscompares++;
                    $display("FAIL seq_rate[%0d]: interval=%0d want 2", k, cyc + 1);
                end
            end
            consume(1'b0, 32'h0, v);
            vectors++;
            if (v !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_pulse[%0d]: instr_valid after consume=%b want 0", k, v);
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (accepted.size() <= i || accepted[i] !== RESET_PC + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL seq_accept[%0d]: size=%0d want addr %h", i, accepted.size(), RESET_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wait();
        int          cyc;
        bit          bad;
        bit          got;
        logic        v;
        logic [31:0] exp;
        do_reset();
        ready_dly  = 3;
        rvalid_dly = 2;
        spurious   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = RESET_PC + 32'(4 * k);
            fetch_one(exp, cyc, bad, got);
            vectors++;
            if (!got || bad || {PC, Instr} !== {exp, image(exp)}) begin
                miscompares++;
                $display("FAIL wait_fetch[%0d]: got=%0b addr_bad=%0b PC=%h Instr=%h want %h %h",
                         k, got, bad, PC, Instr, exp, image(exp));
            end
            if (k > 0) begin
                vectors++;
                if (cyc != 6) begin
                    miscompares++;
                    $display("FAIL wait_rate[%0d]: interval=%0d want 7", k, cyc + 1);
                end
            end
            consume(1'b0, 32'h0, v);
            vectors++;
            if (v !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_pulse[%0d]: instr_valid after consume=%b want 0", k, v);
            end
        end
        spurious = 1'b0;
    endtask

    task automatic test_stall();
        int   cyc;
        bit   bad;
        bit   got;
        logic v;
        do_reset();
        fetch_one(32'h0, cyc, bad, got);
        consume(1'b0, 32'h0, v);
        fetch_one(32'h4, cyc, bad, got);
        stall    = 1'b1;
        spurious = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({instr_valid, imem_req, PC, Instr} !== {1'b1, 1'b0, 32'h4, image(32'h4)}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b req=%b PC=%h Instr=%h want 1 0 00000004 %h",
                         i, instr_valid, imem_req, PC, Instr, image(32'h4));
            end
        end
        spurious = 1'b0;
        stall    = 1'b0;
        consume(1'b0, 32'h0, v);
        vectors++;
        if ({v, imem_req, PC, imem_addr} !== {1'b0, 1'b1, 32'h8, 32'h8}) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b req=%b PC=%h addr=%h want 0 1 00000008 00000008",
                     v, imem_req, PC, imem_addr);
        end
    endtask

    task automatic test_redirect();
        int          cyc;
        bit          bad;
        bit          got;
        logic        v;
        logic [31:0] seq [7];
        seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44};
        do_reset();
        rvalid_dly = 2;
        for (int k = 0; k < 7; k++) begin
            fetch_one(seq[k], cyc, bad, got);
            vectors++;
            if (!got || bad || {PC, Instr} !== {seq[k], image(seq[k])}) begin
                miscompares++;
                $display("FAIL redir_fetch[%0d]: got=%0b addr_bad=%0b PC=%h Instr=%h want %h %h",
                         k, got, bad, PC, Instr, seq[k], image(seq[k]));
            end
            if (k < 6) consume(k == 4, 32'h40, v);
        end
        consume(1'b1, 32'hFFFF_FFFC, v);
        vectors++;
        if ({imem_req, imem_addr, Instr} !== {1'b1, 32'hFFFF_FFFC, image(32'h44)}) begin
            miscompares++;
            $display("FAIL redir_target: req=%b addr=%h Instr=%h want 1 fffffffc %h",
                     imem_req, imem_addr, Instr, image(32'h44));
        end
        fetch_one(32'hFFFF_FFFC, cyc, bad, got);
        vectors++;
        if (!got || PCPlus4 !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_plus4: got=%0b PCPlus4=%h want 00000000", got, PCPlus4);
        end
        consume(1'b0, 32'h0, v);
        fetch_one(32'h0, cyc, bad, got);
        vectors++;
        if (!got || bad || {PC, Instr} !== {32'h0, image(32'h0)}) begin
            miscompares++;
            $display("FAIL wrap_fetch: got=%0b bad=%0b PC=%h Instr=%h want 00000000 %h",
                     got, bad, PC, Instr, image(32'h0));
        end
    endtask

    task automatic test_reset_mid();
        int   cyc;
        bit   bad;
        bit   got;
        logic v;
        do_reset();
        rvalid_dly = 3;
        fetch_one(32'h0, cyc, bad, got);
        consume(1'b0, 32'h0, v);
        @(negedge clk);
        #1;
        vectors++;
        if ({imem_req, instr_valid, PC} !== {1'b0, 1'b0, 32'h4}) begin
            miscompares++;
            $display("FAIL mid_in_wait: req=%b valid=%b PC=%h want 0 0 00000004", imem_req, instr_valid, PC);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({imem_req, instr_valid, misalign, PC, Instr} !== {3'b000, RESET_PC, NOP}) begin
            miscompares++;
            $display("FAIL mid_reset: req=%b valid=%b mis=%b PC=%h Instr=%h want 0 0 0 %h %h",
                     imem_req, instr_valid, misalign, PC, Instr, RESET_PC, NOP);
        end
        repeat (2) @(negedge clk);
        accepted.delete();
        reset = 1'b0;
        fetch_one(RESET_PC, cyc, bad, got);
        vectors++;
        if (!got || bad || {PC, Instr} !== {RESET_PC, image(RESET_PC)} ||
            accepted.size() == 0 || accepted[0] !== RESET_PC) begin
            miscompares++;
            $display("FAIL mid_refetch: got=%0b bad=%0b PC=%h Instr=%h want %h %h",
                     got, bad, PC, Instr, RESET_PC, image(RESET_PC));
        end
    endtask

    task automatic test_misalign();
        int   cyc;
        bit   bad;
        bit   got;
        logic v;
        do_reset();
        fetch_one(32'h0, cyc, bad, got);
        consume(1'b1, 32'h42, v);
`ifdef FETCH_MISALIGN_CHECK_EN
        vectors++;
        if ({misalign, imem_req, v, PC} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL misalign_trap: mis=%b req=%b valid=%b PC=%h want 1 0 0 00000000",
                     misalign, imem_req, v, PC);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({misalign, imem_req, instr_valid} !== 3'b100) begin
                miscompares++;
                $display("FAIL misalign_halt[%0d]: mis/req/valid=%b want 100", i, {misalign, imem_req, instr_valid});
            end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_clear: misalign=%b want 0", misalign);
        end
        reset = 1'b0;
`else
        vectors++;
        if ({misalign, imem_req, imem_addr} !== {2'b01, 32'h40}) begin
            miscompares++;
            $display("FAIL misalign_off: mis=%b req=%b addr=%h want 0 1 00000040", misalign, imem_req, imem_addr);
        end
        fetch_one(32'h40, cyc, bad, got);
        vectors++;
        if (!got || bad || {PC, Instr} !== {32'h40, image(32'h40)}) begin
            miscompares++;
            $display("FAIL misalign_off_fetch: got=%0b bad=%0b PC=%h Instr=%h want 00000040 %h",
                     got, bad, PC, Instr, image(32'h40));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

endmodule
